// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key debounce / event block.
// key_evt_t describes one FIFO word for the default 4-input build.
package key_evt_pkg;

   localparam int unsigned KEY_IN_NUM = 4;

   function automatic int unsigned evt_width(input int unsigned in_num);
      return 2 * in_num;
   endfunction

   localparam int unsigned EVT_W = evt_width(KEY_IN_NUM);

   typedef struct packed {
      logic [KEY_IN_NUM-1:0] changed;
      logic [KEY_IN_NUM-1:0] level;
   } key_evt_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic single-clock show-ahead FIFO; head word is visible on pop_data while non-empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Storage needs no reset; the output is masked while empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/key_debounce_event.sv
// Synchronises and debounces raw key pins, publishes clean levels and queues
// one {changed, level} event per accepting sample tick; irq follows FIFO non-empty.
module key_debounce_event
   import key_evt_pkg::*;
#(
   parameter int unsigned IN_NUM     = 4,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned SAMPLE_DIV = 1000,
   parameter int unsigned STABLE_CNT = 8,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IN_NUM-1:0]             raw_in,
   output logic [IN_NUM-1:0]             level_out,
   output logic                          evt_valid,
   output logic [evt_width(IN_NUM)-1:0]  evt_data,
   input  logic                          evt_pop,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          irq
);

   localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
   localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [IN_NUM-1:0] INACTIVE = {IN_NUM{ACTIVE_LOW}};

   logic [IN_NUM-1:0] sync1_q, sync2_q;
   logic [IN_NUM-1:0] s;
   logic [DIV_W-1:0]  presc_q;
   logic              tick;
   logic [IN_NUM-1:0] level_q, level_d, changed;
   logic [CNT_W-1:0]  cnt_q [IN_NUM];
   logic [CNT_W-1:0]  cnt_d [IN_NUM];
   logic              push, fifo_full, fifo_empty;
   logic              overflow_q;

   assign s    = sync2_q ^ INACTIVE;
   assign tick = (presc_q == DIV_W'(SAMPLE_DIV - 1));

   always_comb begin
      level_d = level_q;
      changed = '0;
      for (int i = 0; i < IN_NUM; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (s[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(STABLE_CNT - 1)) begin
               level_d[i] = ~level_q[i];
               cnt_d[i]   = '0;
               changed[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= INACTIVE;
         sync2_q    <= INACTIVE;
         presc_q    <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < IN_NUM; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         presc_q <= tick ? '0 : presc_q + DIV_W'(1);
         level_q <= level_d;
         for (int i = 0; i < IN_NUM; i++) cnt_q[i] <= cnt_d[i];
         // A dropped word must stay visible even if firmware clears in the same cycle.
         if (push && fifo_full && !evt_pop) overflow_q <= 1'b1;
         else if (ovf_clr)                  overflow_q <= 1'b0;
      end
   end

   assign push = tick & (|changed);

   sync_fifo_fwft #(
      .WIDTH (evt_width(IN_NUM)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({changed, level_d}),
      .pop       (evt_pop),
      .pop_data  (evt_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (evt_count)
   );

   assign level_out = level_q;
   assign evt_valid = ~fifo_empty;
   assign irq       = ~fifo_empty;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_debounce_event.sv
// Bench for key_debounce_event: vector table for steady-state debounce/event checks,
// scoreboard queue of expected events, hand sequences for timing corner cases.
module tb_key_debounce_event;
   import key_evt_pkg::*;

   localparam int unsigned SAMPLE_DIV = 4;
   localparam int unsigned STABLE_CNT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw_in;
   logic [3:0] level_out;
   logic       evt_valid;
   logic [7:0] evt_data;
   logic       evt_pop;
   logic [2:0] evt_count;
   logic       overflow;
   logic       ovf_clr;
   logic       irq;

   key_debounce_event #(
      .IN_NUM     (4),
      .ACTIVE_LOW (1'b1),
      .SAMPLE_DIV (SAMPLE_DIV),
      .STABLE_CNT (STABLE_CNT),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in),
      .level_out (level_out),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .evt_pop   (evt_pop),
      .evt_count (evt_count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Posedges since reset release; sample ticks land on multiples of SAMPLE_DIV.
   int ecnt;
   always @(posedge clk or posedge rst) begin
      if (rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   typedef struct {
      logic [3:0] raw;
      logic [3:0] level;
      logic [3:0] changed;
   } vec_t;

   vec_t     vecs[7];
   key_evt_t sb[$];
   int       n_vec = 0;
   int       n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Edge index on which a level driven now is accepted (2-flop sync, then STABLE_CNT ticks).
   function automatic int accept_edge(input int m);
      int first;
      int tick_ge;
      first   = m + 3;
      tick_ge = ((first + SAMPLE_DIV - 1) / SAMPLE_DIV) * SAMPLE_DIV;
      return tick_ge + (STABLE_CNT - 1) * SAMPLE_DIV;
   endfunction

   task automatic drain(input string tag);
      key_evt_t e;
      check({tag, "_count"}, 32'(evt_count), 32'(sb.size()));
      for (int k = 0; k < 8 && evt_valid; k++) begin
         check({tag, "_irq"}, 32'(irq), 32'd1);
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_extra: got event %h, required none", tag, evt_data);
         end else begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(evt_data), 32'(e));
         end
         evt_pop = 1'b1;
         @(negedge clk);
         evt_pop = 1'b0;
      end
      check({tag, "_empty"}, 32'(evt_count), 32'd0);
      check({tag, "_irq_low"}, 32'(irq), 32'd0);
      check({tag, "_missing"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      int acc;
      int t2;
      key_evt_t e;

      vecs[0] = '{raw: 4'hF, level: 4'h0, changed: 4'h0};
      vecs[1] = '{raw: 4'hE, level: 4'h1, changed: 4'h1};
      vecs[2] = '{raw: 4'hF, level: 4'h0, changed: 4'h1};
      vecs[3] = '{raw: 4'h5, level: 4'hA, changed: 4'hA};
      vecs[4] = '{raw: 4'hF, level: 4'h0, changed: 4'hA};
      vecs[5] = '{raw: 4'h0, level: 4'hF, changed: 4'hF};
      vecs[6] = '{raw: 4'hF, level: 4'h0, changed: 4'hF};

      rst = 1'b1; raw_in = 4'hF; evt_pop = 1'b0; ovf_clr = 1'b0;
      cyc(2);
      check("rst_level", 32'(level_out), 32'h0);
      check("rst_valid", 32'(evt_valid), 32'h0);
      check("rst_data", 32'(evt_data), 32'h0);
      check("rst_count", 32'(evt_count), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      rst = 1'b0;

      foreach (vecs[v]) begin
         raw_in = vecs[v].raw;
         if (vecs[v].changed != 4'h0) begin
            e.changed = vecs[v].changed;
            e.level   = vecs[v].level;
            sb.push_back(e);
         end
         cyc(16);
         check($sformatf("vec%0d_level", v), 32'(level_out), 32'(vecs[v].level));
         drain($sformatf("vec%0d", v));
      end

      // Bounce: 5-cycle windows hold at most two ticks, never enough to accept.
      for (int k = 0; k < 12; k++) begin
         raw_in[0] = ~raw_in[0];
         cyc(5);
      end
      raw_in = 4'hF;
      cyc(20);
      check("bounce_level", 32'(level_out), 32'h0);
      check("bounce_count", 32'(evt_count), 32'h0);

      // Five transitions on key2 without popping; the fifth is dropped.
      for (int k = 0; k < 5; k++) begin
         raw_in = (k % 2 == 0) ? 4'b1011 : 4'b1111;
         if (k < 4) begin
            e.changed = 4'b0100;
            e.level   = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            sb.push_back(e);
         end
         cyc(16);
         if (k == 3) check("ovf_before_full_drop", 32'(overflow), 32'h0);
      end
      check("ovf_count", 32'(evt_count), 32'd4);
      check("ovf_flag", 32'(overflow), 32'h1);
      check("ovf_head", 32'(evt_data), 32'h44);
      check("ovf_level", 32'(level_out), 32'h4);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'h0);

      // Full FIFO: release key2 and pop on exactly the accepting edge.
      raw_in = 4'hF;
      m      = ecnt;
      acc    = accept_edge(m);
      while (ecnt < acc - 1) @(negedge clk);
      check("fullpop_pre_level", 32'(level_out), 32'h4);
      check("fullpop_pre_count", 32'(evt_count), 32'd4);
      evt_pop = 1'b1;
      @(negedge clk);
      evt_pop = 1'b0;
      void'(sb.pop_front());
      e.changed = 4'b0100;
      e.level   = 4'b0000;
      sb.push_back(e);
      check("fullpop_level", 32'(level_out), 32'h0);
      check("fullpop_count", 32'(evt_count), 32'd4);
      check("fullpop_head", 32'(evt_data), 32'(sb[0]));
      check("fullpop_ovf", 32'(overflow), 32'h0);
      drain("fullpop");

      // Reset mid-debounce with key3 accepted and queued, key0 in its window.
      raw_in = 4'b0111;
      e.changed = 4'b1000;
      e.level   = 4'b1000;
      sb.push_back(e);
      cyc(16);
      check("prerst_level", 32'(level_out), 32'h8);
      check("prerst_count", 32'(evt_count), 32'd1);
      raw_in = 4'b0110;
      m      = ecnt;
      t2     = accept_edge(m) - SAMPLE_DIV;
      while (ecnt < t2 - 1) @(negedge clk);
      rst = 1'b1;
      #1;
      sb.delete();
      check("midrst_level", 32'(level_out), 32'h0);
      check("midrst_valid", 32'(evt_valid), 32'h0);
      check("midrst_data", 32'(evt_data), 32'h0);
      check("midrst_count", 32'(evt_count), 32'h0);
      check("midrst_ovf", 32'(overflow), 32'h0);
      check("midrst_irq", 32'(irq), 32'h0);
      cyc(2);
      rst = 1'b0;
      cyc(11);
      check("postrst_early_level", 32'(level_out), 32'h0);
      check("postrst_early_count", 32'(evt_count), 32'h0);
      cyc(1);
      check("postrst_level", 32'(level_out), 32'h9);
      check("postrst_irq", 32'(irq), 32'h1);
      e.changed = 4'b1001;
      e.level   = 4'b1001;
      sb.push_back(e);
      drain("postrst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
